adder_tree_acc: RTL

ADDER_TREE_ACC -- requirements
Module: adder_tree_acc

---
 rtl/adder_tree_pkg.sv | 31 +++
 rtl/adder_tree_level.sv | 47 ++++
 rtl/adder_tree_acc.sv | 102 ++++++++++
 3 files changed

// File: rtl/adder_tree_pkg.sv
// Shared constants and width helpers for the pipelined adder tree accumulator.
package adder_tree_pkg;

  localparam int unsigned DEF_BITWIDTH  = 32;
  localparam int unsigned DEF_NUM_IN    = 4;
  localparam int unsigned DEF_ACC_GUARD = 8;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

  function automatic int unsigned levels_of(input int unsigned num_in);
    return clog2(num_in);
  endfunction

  function automatic int unsigned sum_w_of(input int unsigned bitwidth,
                                           input int unsigned num_in);
    return bitwidth + levels_of(num_in);
  endfunction

  function automatic int unsigned out_w_of(input int unsigned bitwidth,
                                           input int unsigned num_in,
                                           input int unsigned acc_guard);
    return sum_w_of(bitwidth, num_in) + acc_guard;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered adder tree level: N operands of W bits reduced pairwise to
// N/2 sums of W+1 bits, with the beat valid and mode tag carried alongside.
module adder_tree_level
  import adder_tree_pkg::*;
#(
  parameter int unsigned W = 8,
  parameter int unsigned N = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic [N*W-1:0]           opnd,
  input  logic                     opnd_valid,
  input  logic                     opnd_acc,
  output logic [(N/2)*(W+1)-1:0]   sum,
  output logic                     sum_valid,
  output logic                     sum_acc
);

  logic [(N/2)*(W+1)-1:0] pair_sum;

  // Pairwise widened addition of adjacent operands.
  always_comb begin
    pair_sum = '0;
    for (int unsigned i = 0; i < N/2; i++) begin
      pair_sum[i*(W+1) +: (W+1)] = {1'b0, opnd[(2*i)*W +: W]}
                                 + {1'b0, opnd[(2*i+1)*W +: W]};
    end
  end

  // Stage register: clear beats regardless of enable, otherwise advance on enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      sum_valid <= 1'b0;
      sum_acc   <= 1'b0;
    end else if (clr) begin
      sum_valid <= 1'b0;
    end else if (en) begin
      sum       <= pair_sum;
      sum_valid <= opnd_valid;
      sum_acc   <= opnd_acc;
    end
  end

endmodule

// File: rtl/adder_tree_acc.sv
// Pipelined adder tree feeding a wrap-around accumulator with a sticky
// overflow flag. One register per tree level plus the accumulator register.
module adder_tree_acc
  import adder_tree_pkg::*;
#(
  parameter int unsigned BITWIDTH  = DEF_BITWIDTH,
  parameter int unsigned NUM_IN    = DEF_NUM_IN,
  parameter int unsigned ACC_GUARD = DEF_ACC_GUARD,
  localparam int unsigned LEVELS   = levels_of(NUM_IN),
  localparam int unsigned SUM_W    = sum_w_of(BITWIDTH, NUM_IN),
  localparam int unsigned OUT_W    = out_w_of(BITWIDTH, NUM_IN, ACC_GUARD)
) (
  input  logic                       iClk,
  input  logic                       iRst,
  input  logic                       iEn,
  input  logic                       iClr,
  input  logic                       iValid,
  input  logic                       iAcc,
  input  logic [NUM_IN*BITWIDTH-1:0] iData,
  output logic [OUT_W-1:0]           oData,
  output logic                       oValid,
  output logic                       oOvf
);

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int unsigned W = BITWIDTH + l;
    localparam int unsigned N = NUM_IN >> l;

    logic [N*W-1:0]         opnd;
    logic                   opnd_valid;
    logic                   opnd_acc;
    logic [(N/2)*(W+1)-1:0] sum;
    logic                   sum_valid;
    logic                   sum_acc;

    if (l == 0) begin : g_src
      assign opnd       = iData;
      assign opnd_valid = iValid;
      assign opnd_acc   = iAcc;
    end else begin : g_chain
      assign opnd       = g_lvl[l-1].sum;
      assign opnd_valid = g_lvl[l-1].sum_valid;
      assign opnd_acc   = g_lvl[l-1].sum_acc;
    end

    adder_tree_level #(
      .W (W),
      .N (N)
    ) u_level (
      .clk        (iClk),
      .rst        (iRst),
      .en         (iEn),
      .clr        (iClr),
      .opnd       (opnd),
      .opnd_valid (opnd_valid),
      .opnd_acc   (opnd_acc),
      .sum        (sum),
      .sum_valid  (sum_valid),
      .sum_acc    (sum_acc)
    );
  end

  logic [SUM_W-1:0] tree_sum;
  logic             tree_valid;
  logic             tree_acc;
  logic [OUT_W:0]   acc_next;

  assign tree_sum   = g_lvl[LEVELS-1].sum;
  assign tree_valid = g_lvl[LEVELS-1].sum_valid;
  assign tree_acc   = g_lvl[LEVELS-1].sum_acc;

  // Accumulate with one extra bit so the wrap carry is visible.
  always_comb begin
    acc_next = {1'b0, oData} + {{(OUT_W+1-SUM_W){1'b0}}, tree_sum};
  end

  // Accumulator, sticky overflow and one-shot update strobe.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oData  <= '0;
      oValid <= 1'b0;
      oOvf   <= 1'b0;
    end else if (iClr) begin
      oData  <= '0;
      oValid <= 1'b0;
      oOvf   <= 1'b0;
    end else if (iEn) begin
      oValid <= tree_valid;
      if (tree_valid) begin
        if (tree_acc) begin
          oData <= acc_next[OUT_W-1:0];
          if (acc_next[OUT_W]) oOvf <= 1'b1;
        end else begin
          oData <= {{(OUT_W-SUM_W){1'b0}}, tree_sum};
        end
      end
    end else begin
      oValid <= 1'b0;
    end
  end

endmodule
